// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the multicycle MIPS controller
//
// Purpose: opcode constants, the FSM state encoding, ALU/mux select
//          encodings, the packed control word and the retire rule.
// Ports:   none (package).

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ_EX   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // True on the last cycle of every instruction; a store only finishes
  // once memory accepts the write.
  function automatic logic retires(state_t s, logic mem_ready);
    case (s)
      S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BEQ_EX, S_JUMP: return 1'b1;
      S_MEMWR: return mem_ready;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational state to control-word map
//
// Purpose: Moore control outputs for each FSM state; only FETCH looks at
//          mem_ready (IR and PC load on the cycle the fetch completes).
// Ports:   state_i     current FSM state
//          mem_ready_i memory completes this cycle
//          ctrl_o      full datapath control word

module control_decode
  import mips_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.memto_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.branch    = 1'b1;
        ctrl_o.pc_src    = PC_ALUOUT;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with trap and retire counter
//
// Purpose: sequences a shared-memory single-ALU MIPS datapath through
//          fetch/decode/execute states, stretches memory states on
//          mem_ready, traps on unknown opcodes and counts retired instructions.
// Ports:   clk, rst_n (async active-low), OpCode (IR[31:26]), mem_ready;
//          datapath controls PCWrite..PCSrc; illegal (sticky trap flag);
//          state_o (debug state); retired (CNT_W-bit retire count).

module multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OpCode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (OpCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      // Only lw/sw reach MEMADR, so anything that is not sw is a load.
      S_MEMADR:   state_d = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BEQ_EX, S_JUMP: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_RESET;
    endcase
  end

  // The flag is set on the edge that enters TRAP so it is already high
  // in the first TRAP cycle.
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    retired_d = retired_q;
    if (retires(state_q, mem_ready)) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  control_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_w)
  );

  always_comb begin
    PCWrite  = ctrl_w.pc_write;
    Branch   = ctrl_w.branch;
    IorD     = ctrl_w.iord;
    MemRead  = ctrl_w.mem_read;
    MemWrite = ctrl_w.mem_write;
    IRWrite  = ctrl_w.ir_write;
    MemtoReg = ctrl_w.memto_reg;
    RegDst   = ctrl_w.reg_dst;
    RegWrite = ctrl_w.reg_write;
    ALUSrcA  = ctrl_w.alu_src_a;
    ALUSrcB  = ctrl_w.alu_src_b;
    ALUOp    = ctrl_w.alu_op;
    PCSrc    = ctrl_w.pc_src;
    illegal  = illegal_q;
    state_o  = state_q;
    retired  = retired_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control

module tb_multicycle_control;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ready;
  logic [5:0]  OpCode;
  logic        PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic [3:0]  state_o;
  logic [31:0] retired;

  logic        s_PCWrite, s_Branch, s_IorD, s_MemRead, s_MemWrite, s_IRWrite;
  logic        s_MemtoReg, s_RegDst, s_RegWrite, s_ALUSrcA, s_illegal;
  logic [1:0]  s_ALUSrcB, s_ALUOp, s_PCSrc;
  logic [3:0]  s_state_o;
  logic [1:0]  s_retired;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .illegal(illegal), .state_o(state_o), .retired(retired)
  );

  // Narrow counter copy so wraparound is reachable in a short run.
  multicycle_control #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(s_PCWrite), .Branch(s_Branch), .IorD(s_IorD), .MemRead(s_MemRead),
    .MemWrite(s_MemWrite), .IRWrite(s_IRWrite), .MemtoReg(s_MemtoReg), .RegDst(s_RegDst),
    .RegWrite(s_RegWrite), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ALUOp(s_ALUOp),
    .PCSrc(s_PCSrc), .illegal(s_illegal), .state_o(s_state_o), .retired(s_retired)
  );

  wire [15:0] ctrl_v = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                        RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_ret;
  logic [15:0] cv_q[$];
  logic [3:0]  st_q[$];
  int          len;

  typedef struct {
    logic [5:0] op;
    int         wf;
    int         wm;
    int         exp_len;
    int         exp_rw;
    int         exp_mw;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_ADDI || op == OP_J;
  endfunction

  // Reference: FETCH-to-FETCH latency and per-instruction write activity.
  function automatic int model_len(input logic [5:0] op, input int wf, input int wm);
    case (op)
      OP_LW:            return 5 + wf + wm;
      OP_SW:            return 4 + wf + wm;
      OP_RTYPE, OP_ADDI: return 4 + wf;
      default:          return 3 + wf;
    endcase
  endfunction

  function automatic int model_rw(input logic [5:0] op);
    return (op == OP_LW || op == OP_RTYPE || op == OP_ADDI) ? 1 : 0;
  endfunction

  function automatic int model_mw(input logic [5:0] op, input int wm);
    return (op == OP_SW) ? wm + 1 : 0;
  endfunction

  // Starts at a negedge in the first FETCH cycle; returns at the next FETCH entry.
  // wf stall cycles in FETCH, wm stall cycles in MEMRD/MEMWR, other cycles random.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    bit mem_op = (op == OP_LW || op == OP_SW);
    bit left = 0;
    cv_q.delete();
    st_q.delete();
    len = -1;
    OpCode = op;
    for (int i = 0; i < 64; i++) begin
      if (i < wf) mem_ready = 1'b0;
      else if (i == wf) mem_ready = 1'b1;
      else if (mem_op && i >= wf + 3 && i < wf + 3 + wm) mem_ready = 1'b0;
      else if (mem_op && i == wf + 3 + wm) mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (state_o != 4'd1) left = 1;
      else if (left) begin
        len = i;
        break;
      end
      cv_q.push_back(ctrl_v);
      st_q.push_back(state_o);
      @(negedge clk);
    end
  endtask

  task automatic check_instr(input string name, input int exp_len, input int exp_rw,
                             input int exp_mw);
    int irw = 0, rw = 0, mw = 0;
    chk({name, "_len"}, len, exp_len);
    foreach (cv_q[k]) begin
      if (cv_q[k][10]) irw++;
      if (cv_q[k][7]) rw++;
      if (cv_q[k][11] && cv_q[k][13]) mw++;
      if (cv_q[k][11] && !cv_q[k][13]) mw += 100;
    end
    chk({name, "_irwrite_pulses"}, irw, 1);
    chk({name, "_regwrite_cycles"}, rw, exp_rw);
    chk({name, "_memwrite_cycles"}, mw, exp_mw);
    exp_ret = exp_ret + 1;
    chk({name, "_retired"}, retired, exp_ret);
    chk({name, "_retired_wrap"}, {30'd0, s_retired}, {30'd0, exp_ret[1:0]});
  endtask

  // Illegal opcode: enters TRAP, holds it, then recovers through async reset.
  task automatic run_trap(input logic [5:0] op, input int wf, input int hold);
    int bad_cycles = 0;
    OpCode = op;
    for (int i = 0; i < wf + 2; i++) begin
      mem_ready = (i < wf) ? 1'b0 : (i == wf) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #1;
    chk("trap_state", state_o, 4'd13);
    chk("trap_illegal", illegal, 1'b1);
    for (int i = 0; i < hold; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      OpCode = 6'($urandom_range(0, 63));
      @(negedge clk);
      #1;
      if (!(illegal === 1'b1 && state_o === 4'd13 && retired === exp_ret && ctrl_v === 16'h0))
        bad_cycles++;
    end
    chk("trap_hold_bad_cycles", bad_cycles, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("trap_reset_illegal", illegal, 1'b0);
    chk("trap_reset_retired", retired, 32'd0);
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("trap_recover_fetch", state_o, 4'd1);
  endtask

  initial begin
    vecs[0] = '{OP_LW,   2, 3, 10, 1, 0};
    vecs[1] = '{OP_SW,   0, 2, 6,  0, 3};
    vecs[2] = '{OP_BEQ,  0, 0, 3,  0, 0};
    vecs[3] = '{OP_J,    0, 0, 3,  0, 0};
    vecs[4] = '{OP_ADDI, 1, 0, 5,  1, 0};
    vecs[5] = '{OP_LW,   0, 0, 5,  1, 0};
    vecs[6] = '{OP_SW,   1, 0, 5,  0, 1};
    vecs[7] = '{OP_RTYPE, 2, 0, 6, 1, 0};

    rst_n = 1'b0;
    mem_ready = 1'b1;
    OpCode = 6'd0;
    exp_ret = 0;

    repeat (3) @(negedge clk);
    chk("reset_state", state_o, 4'd0);
    chk("reset_ctrl", ctrl_v, 16'h0);
    chk("reset_illegal", illegal, 1'b0);
    chk("reset_retired", retired, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_state_before_edge", state_o, 4'd0);
    @(negedge clk);
    chk("release_fetch", state_o, 4'd1);

    run_instr(OP_RTYPE, 0, 0);
    check_instr("rtype", 4, 1, 0);
    if (st_q.size() == 4) begin
      chk("rtype_s0", st_q[0], 4'd1);
      chk("rtype_s1", st_q[1], 4'd2);
      chk("rtype_s2", st_q[2], 4'd7);
      chk("rtype_s3", st_q[3], 4'd8);
      chk("rtype_cv_fetch", cv_q[0], 16'h9410);
      chk("rtype_cv_decode", cv_q[1], 16'h0030);
      chk("rtype_cv_ex", cv_q[2], 16'h0048);
      chk("rtype_cv_wb", cv_q[3], 16'h0180);
    end else chk("rtype_trace_size", st_q.size(), 4);

    run_instr(OP_LW, 2, 3);
    check_instr("lw_waits", 10, 1, 0);
    if (st_q.size() == 10) begin
      chk("lw_memwb_state", st_q[9], 4'd5);
      chk("lw_memwb_cv", cv_q[9], 16'h0280);
    end else chk("lw_trace_size", st_q.size(), 10);

    run_instr(OP_BEQ, 0, 0);
    check_instr("beq", 3, 0, 0);
    if (cv_q.size() == 3) chk("beq_cv", cv_q[2], 16'h4045);
    else chk("beq_trace_size", cv_q.size(), 3);

    run_instr(OP_J, 0, 0);
    check_instr("jump", 3, 0, 0);
    if (cv_q.size() == 3) chk("jump_cv", cv_q[2], 16'h8002);
    else chk("jump_trace_size", cv_q.size(), 3);

    for (int v = 0; v < 8; v++) begin
      run_instr(vecs[v].op, vecs[v].wf, vecs[v].wm);
      check_instr($sformatf("vec%0d", v), vecs[v].exp_len, vecs[v].exp_rw, vecs[v].exp_mw);
    end

    run_trap(6'b111111, 0, 20);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      int wf, wm, pick;
      pick = $urandom_range(0, 7);
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      case (pick)
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        6: op = OP_LW;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (is_legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      if (is_legal(op)) begin
        run_instr(op, wf, wm);
        check_instr($sformatf("rand%0d_op%0h", n, op), model_len(op, wf, wm),
                    model_rw(op), model_mw(op, wm));
      end else begin
        run_trap(op, wf, $urandom_range(2, 6));
      end
    end

    // Reset mid-load aborts without counting.
    OpCode = OP_LW;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("abort_in_memrd", state_o, 4'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_state", state_o, 4'd0);
    chk("abort_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
